ex_mem_stage: RTL and testbench

- Pipeline boundary between the Execute stage (ALU, PADDSB, shifter, reduction unit) and the Memory stage of the 16-bit CPU.
- Registers the selected Execute result plus memory and writeback control into the EX/MEM register.
- Owns the architectural N/Z/V flag register and updates it per opcode as each instruction advances.
- Handles memory-side stall, control-hazard flush (including flush arriving during a stall) and halt freeze.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/ex_mem_stage_if.sv | 28 ++
 rtl/ex_mem_stage_flag_reg.sv | 30 +++
 rtl/ex_mem_stage.sv | 49 ++++
 tb/tb_ex_mem_stage.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, datapath widths and flag bit positions for the 16-bit CPU
package cpu_pkg;
  localparam int DATA_W  = 16;
  localparam int RADDR_W = 4;
  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX-side inputs, pipeline controls and registered MEM-side outputs
interface ex_mem_stage_if
  import cpu_pkg::*;
#(parameter int DW = DATA_W, parameter int AW = RADDR_W);
  logic          stall, flush;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [DW-1:0] ex_result, ex_store_data;
  logic          ex_ovfl;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_halt;
  logic          mem_valid;
  logic [DW-1:0] mem_result, mem_store_data;
  logic [AW-1:0] mem_rd;
  logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
  modport master (
    output stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_halt,
    input  mem_valid, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_halt
  );
  modport slave (
    input  stall, flush, ex_valid, ex_opcode, ex_result, ex_ovfl, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_halt,
    output mem_valid, mem_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, mem_halt
  );
endinterface

// File: rtl/ex_mem_stage_flag_reg.sv
// flag_reg: architectural N/Z/V register with per-opcode update selection
module flag_reg
  import cpu_pkg::*;
#(parameter int DW = DATA_W) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] result,
  input  logic          ovfl,
  output logic          n,
  output logic          z,
  output logic          v
);
  logic [2:0] f;
  logic       arith, z_upd;
  assign arith = opcode == OP_ADD || opcode == OP_SUB;
  assign z_upd = arith || opcode == OP_XOR || opcode == OP_SLL || opcode == OP_SRA || opcode == OP_ROR;
  always_ff @(posedge clk) begin
    if (rst) f <= '0;
    else if (en) begin
      f[FLAG_Z] <= z_upd ? result == '0 : f[FLAG_Z];
      f[FLAG_N] <= arith ? result[DW-1] : f[FLAG_N];
      f[FLAG_V] <= arith ? ovfl : f[FLAG_V];
    end
  end
  assign n = f[FLAG_N];
  assign z = f[FLAG_Z];
  assign v = f[FLAG_V];
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with flags, stall, deferred flush and halt freeze
module ex_mem_stage
  import cpu_pkg::*;
#(parameter int DATA_W = cpu_pkg::DATA_W, parameter int RADDR_W = cpu_pkg::RADDR_W) (
  input  logic           clk,
  input  logic           rst,
  ex_mem_stage_if.slave  bus,
  output logic           flag_n,
  output logic           flag_z,
  output logic           flag_v,
  output logic           halted
);
  logic squash_pending, adv, kill, load;
  assign adv  = !bus.stall && !halted;
  assign kill = bus.flush || squash_pending;
  assign load = adv && bus.ex_valid && !kill;
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_pending     <= 1'b0;
      halted             <= 1'b0;
      bus.mem_valid      <= 1'b0;
      bus.mem_result     <= '0;
      bus.mem_store_data <= '0;
      bus.mem_rd         <= '0;
      bus.mem_reg_write  <= 1'b0;
      bus.mem_mem_read   <= 1'b0;
      bus.mem_mem_write  <= 1'b0;
      bus.mem_halt       <= 1'b0;
    end else begin
      // a flush seen while stalled is held until the instruction finally advances
      squash_pending <= !adv && (squash_pending || (bus.flush && !halted));
      if (adv) begin
        halted             <= load && bus.ex_halt;
        bus.mem_valid      <= load;
        bus.mem_result     <= load ? bus.ex_result : '0;
        bus.mem_store_data <= load ? bus.ex_store_data : '0;
        bus.mem_rd         <= load ? bus.ex_rd : '0;
        bus.mem_reg_write  <= load && bus.ex_reg_write;
        bus.mem_mem_read   <= load && bus.ex_mem_read;
        bus.mem_mem_write  <= load && bus.ex_mem_write;
        bus.mem_halt       <= load && bus.ex_halt;
      end
    end
  end
  flag_reg #(.DW(DATA_W)) u_flags (
    .clk(clk), .rst(rst), .en(load), .opcode(bus.ex_opcode), .result(bus.ex_result),
    .ovfl(bus.ex_ovfl), .n(flag_n), .z(flag_z), .v(flag_v)
  );
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed checks of the EX/MEM register, flags, stall/flush and halt
module tb_ex_mem_stage;
  import cpu_pkg::*;
  logic clk = 1'b0, rst;
  logic flag_n, flag_z, flag_v, halted;
  int total = 0, fails = 0;
  ex_mem_stage_if bus ();
  ex_mem_stage dut (.clk(clk), .rst(rst), .bus(bus), .flag_n(flag_n), .flag_z(flag_z),
                    .flag_v(flag_v), .halted(halted));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic [3:0] op, input logic [15:0] res, input logic ov,
                    input logic [15:0] sd, input logic [3:0] rd,
                    input logic rw, input logic mr, input logic mw, input logic h);
    bus.ex_valid = 1'b1; bus.ex_opcode = op; bus.ex_result = res; bus.ex_ovfl = ov;
    bus.ex_store_data = sd; bus.ex_rd = rd; bus.ex_reg_write = rw;
    bus.ex_mem_read = mr; bus.ex_mem_write = mw; bus.ex_halt = h;
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] nzv);
    chk({tag, ".nzv"}, {29'd0, flag_n, flag_z, flag_v}, {29'd0, nzv});
  endtask

  initial begin
    rst = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    ex(OP_ADD, 16'h0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ex_valid = 1'b0;
    tick();
    tick();
    chk("rst.valid", bus.mem_valid, 0);
    chk("rst.result", bus.mem_result, 0);
    chk("rst.ctrl", {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write, bus.mem_halt}, 0);
    chk_flags("rst", 3'b000);
    chk("rst.halted", halted, 0);
    rst = 1'b0;
    ex(OP_ADD, 16'h0000, 1'b0, 16'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add.valid", bus.mem_valid, 1);
    chk("add.result", bus.mem_result, 16'h0000);
    chk("add.rd", bus.mem_rd, 4'h3);
    chk("add.rw", bus.mem_reg_write, 1);
    chk_flags("add", 3'b010);
    ex(OP_SUB, 16'h8000, 1'b1, 16'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sub.result", bus.mem_result, 16'h8000);
    chk_flags("sub", 3'b101);
    ex(OP_XOR, 16'h0005, 1'b0, 16'h0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_flags("xor", 3'b101);
    ex(OP_PADDSB, 16'h0000, 1'b1, 16'h0, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("paddsb.result", bus.mem_result, 16'h0000);
    chk_flags("paddsb", 3'b101);
    ex(OP_SW, 16'h0040, 1'b0, 16'h1234, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sw.mw", bus.mem_mem_write, 1);
    chk("sw.store", bus.mem_store_data, 16'h1234);
    chk("sw.result", bus.mem_result, 16'h0040);
    bus.stall = 1'b1;
    ex(OP_ADD, 16'h0000, 1'b0, 16'h0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall1.result", bus.mem_result, 16'h0040);
    chk("stall1.mw", bus.mem_mem_write, 1);
    chk_flags("stall1", 3'b101);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("stall2.store", bus.mem_store_data, 16'h1234);
    chk("stall2.squash", dut.squash_pending, 1);
    tick();
    chk("stall3.valid", bus.mem_valid, 1);
    chk("stall3.squash", dut.squash_pending, 1);
    bus.stall = 1'b0;
    tick();
    chk("release.valid", bus.mem_valid, 0);
    chk("release.mw", bus.mem_mem_write, 0);
    chk("release.rw", bus.mem_reg_write, 0);
    chk("release.squash", dut.squash_pending, 0);
    chk_flags("release", 3'b101);
    ex(OP_ADD, 16'h7FFF, 1'b1, 16'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_flags("sat", 3'b001);
    ex(OP_HLT, 16'h0000, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flushhlt.valid", bus.mem_valid, 0);
    chk("flushhlt.halted", halted, 0);
    chk("flushhlt.squash", dut.squash_pending, 0);
    ex(OP_HLT, 16'h00AA, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("hlt.mem_halt", bus.mem_halt, 1);
    chk("hlt.halted", halted, 1);
    ex(OP_ADD, 16'h0000, 1'b0, 16'h5555, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.flush = i[0];
      tick();
      chk("frozen.result", bus.mem_result, 16'h00AA);
      chk("frozen.halt", {30'd0, bus.mem_halt, halted}, 2'b11);
      chk_flags("frozen", 3'b001);
    end
    bus.flush = 1'b0;
    chk("frozen.rd", bus.mem_rd, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2.halted", halted, 0);
    ex(OP_SW, 16'h0080, 1'b0, 16'hBEEF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("pre_rst.squash", dut.squash_pending, 1);
    rst = 1'b1;
    tick();
    chk("rst3.valid", bus.mem_valid, 0);
    chk("rst3.result", bus.mem_result, 0);
    chk("rst3.store", bus.mem_store_data, 0);
    chk("rst3.mw", bus.mem_mem_write, 0);
    chk("rst3.squash", dut.squash_pending, 0);
    rst = 1'b0;
    bus.stall = 1'b0;
    ex(OP_LW, 16'h0010, 1'b0, 16'h0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("lw.valid", bus.mem_valid, 1);
    chk("lw.result", bus.mem_result, 16'h0010);
    chk("lw.mr", bus.mem_mem_read, 1);
    chk("lw.rd", bus.mem_rd, 4'h5);
    chk_flags("lw", 3'b000);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
